// File: rtl/config_sram.sv
`timescale 1ns/1ps
// config_sram
// Bit-addressable configuration SRAM of 2^ADDR_W bits. It is viewed as an
// array of W-bit words, with W = MAX_W >> c chosen per request.
// Storage is built as NWORDS rows of MAX_W bits. A W-bit word never
// straddles a row because W is a power of two no wider than MAX_W.
//
// Handshake: a request is taken on a rising edge of sram_clk when
// en & ready & ~clear. There is no other back-pressure. rvalid is a
// one-cycle strobe marking d_out, and it has no ready of its own.
//
// Ports
//   sram_clk, sram_rst_n : clock, async active-low reset
//   en, wen              : request valid, 1 = write / 0 = read
//   addr                 : word address at the current width
//   d_in, wmask          : LSB-aligned write data and per-bit write enable
//   c                    : width select, W = MAX_W >> min(c, LG_MAX)
//   reg_out              : read latency 2 instead of 1
//   clear                : zero-fill the whole array
//   ready                : requests are accepted
//   d_out, rvalid        : read data (zero-extended) and its strobe
//   dbg_state            : FSM state, 0 = INIT (zero-fill), 1 = IDLE
module config_sram #(
  parameter int ADDR_W = 15,
  parameter int MAX_W  = 32
) (
  input  logic              sram_clk,
  input  logic              sram_rst_n,
  input  logic              en,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [MAX_W-1:0]  d_in,
  input  logic [MAX_W-1:0]  wmask,
  input  logic [2:0]        c,
  input  logic              reg_out,
  input  logic              clear,
  output logic              ready,
  output logic [MAX_W-1:0]  d_out,
  output logic              rvalid,
  output logic              dbg_state
);

  localparam int LG_MAX = $clog2(MAX_W);
  localparam int NWORDS = (2 ** ADDR_W) / MAX_W;
  localparam int WIDX_W = $clog2(NWORDS);
  localparam int CNT_W  = WIDX_W + 1;

  typedef enum logic {ST_INIT = 1'b0, ST_IDLE = 1'b1} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ready_q;

  logic [MAX_W-1:0]   mem_q [NWORDS];

  // Request decode: word A at width W starts at storage bit A*W.
  // Upper row bits select the row, low LG_MAX bits the offset in the row.
  int                 keff;
  logic [ADDR_W-1:0]  amask;
  logic [ADDR_W-1:0]  bitpos;
  logic [WIDX_W-1:0]  req_widx;
  logic [LG_MAX-1:0]  req_off;
  logic [MAX_W-1:0]   req_wbits;
  logic [MAX_W-1:0]   wr_m;
  logic [MAX_W-1:0]   wr_d;
  logic               accept;

  always_comb begin
    keff      = (int'(c) > LG_MAX) ? LG_MAX : int'(c);
    // Only ADDR_W - LG_MAX + keff address bits address a distinct word.
    amask     = ~({ADDR_W{1'b1}} << (ADDR_W - LG_MAX + keff));
    bitpos    = (addr & amask) << (LG_MAX - keff);
    req_widx  = bitpos[ADDR_W-1:LG_MAX];
    req_off   = bitpos[LG_MAX-1:0];
    // When W = MAX_W the shift yields zero, so the mask is all ones.
    req_wbits = ~({MAX_W{1'b1}} << (MAX_W >> keff));
    wr_m      = (wmask & req_wbits) << req_off;
    wr_d      = (d_in & req_wbits) << req_off;
  end

  assign accept = en & ready_q & ~clear;

  // Storage has no reset. The INIT sweep zeroes one row per cycle.
  always_ff @(posedge sram_clk) begin
    if (state_q == ST_INIT) begin
      mem_q[cnt_q[WIDX_W-1:0]] <= '0;
    end else if (accept && wen) begin
      mem_q[req_widx] <= (mem_q[req_widx] & ~wr_m) | (wr_d & wr_m);
    end
  end

  // Zero-fill FSM
  always_ff @(posedge sram_clk or negedge sram_rst_n) begin
    if (!sram_rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NWORDS - 1)) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (clear) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_INIT;
          cnt_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Read pipeline
  //   a : read captured at the accept edge
  //   b : reg_out=1 result waiting one extra cycle
  //   p : reg_out=0 result pushed back by an older result on the same edge
  // b and p are never valid together. p is only loaded when the request
  // one cycle younger than b's was fast, so no slow result can follow it.
  logic               a_vld_q, a_slow_q;
  logic [WIDX_W-1:0]  a_widx_q;
  logic [LG_MAX-1:0]  a_off_q;
  logic [MAX_W-1:0]   a_wbits_q;
  logic               b_vld_q, p_vld_q;
  logic [MAX_W-1:0]   b_data_q, p_data_q;
  logic [MAX_W-1:0]   d_out_q;
  logic               rvalid_q;
  logic               a_fast;
  logic [MAX_W-1:0]   rd_data_d;

  // Storage is read one edge after accept. A write accepted on that same
  // edge does not land until after the read, so the data is as of accept.
  assign rd_data_d = (mem_q[a_widx_q] >> a_off_q) & a_wbits_q;
  assign a_fast    = a_vld_q & ~a_slow_q;

  always_ff @(posedge sram_clk or negedge sram_rst_n) begin
    if (!sram_rst_n) begin
      a_vld_q   <= 1'b0;
      a_slow_q  <= 1'b0;
      a_widx_q  <= '0;
      a_off_q   <= '0;
      a_wbits_q <= '0;
      b_vld_q   <= 1'b0;
      b_data_q  <= '0;
      p_vld_q   <= 1'b0;
      p_data_q  <= '0;
      d_out_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      a_vld_q <= accept & ~wen;
      if (accept && !wen) begin
        a_slow_q  <= reg_out;
        a_widx_q  <= req_widx;
        a_off_q   <= req_off;
        a_wbits_q <= req_wbits;
      end
      b_vld_q <= a_vld_q & a_slow_q;
      if (a_vld_q && a_slow_q) b_data_q <= rd_data_d;
      p_vld_q <= a_fast & (b_vld_q | p_vld_q);
      if (a_fast) p_data_q <= rd_data_d;
      rvalid_q <= b_vld_q | p_vld_q | a_fast;
      if (b_vld_q)      d_out_q <= b_data_q;
      else if (p_vld_q) d_out_q <= p_data_q;
      else if (a_fast)  d_out_q <= rd_data_d;
    end
  end

  assign ready     = ready_q;
  assign d_out     = d_out_q;
  assign rvalid    = rvalid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_config_sram.sv
`timescale 1ns/1ps
module tb_config_sram;

  localparam int ADDR_W   = 15;
  localparam int MAX_W    = 32;
  localparam int TOT      = 1 << ADDR_W;
  localparam int INIT_CYC = 1024;

  // ---------------- clock / reset / DUT ----------------
  logic              sram_clk   = 1'b0;
  logic              sram_rst_n = 1'b0;
  logic              en = 1'b0, wen = 1'b0, reg_out = 1'b0, clear = 1'b0;
  logic [2:0]        c = '0;
  logic [ADDR_W-1:0] addr = '0;
  logic [MAX_W-1:0]  d_in = '0, wmask = '0;
  logic              ready, rvalid, dbg_state;
  logic [MAX_W-1:0]  d_out;

  always #5 sram_clk = ~sram_clk;

  config_sram #(.ADDR_W(ADDR_W), .MAX_W(MAX_W)) dut (
    .sram_clk  (sram_clk),
    .sram_rst_n(sram_rst_n),
    .en        (en),
    .wen       (wen),
    .addr      (addr),
    .d_in      (d_in),
    .wmask     (wmask),
    .c         (c),
    .reg_out   (reg_out),
    .clear     (clear),
    .ready     (ready),
    .d_out     (d_out),
    .rvalid    (rvalid),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int               n_cmp = 0;
  int               n_fail = 0;
  int               cyc = 0;
  logic [TOT-1:0]   m_mem;
  bit               m_ready;
  int               m_init_left;
  logic [MAX_W-1:0] m_last;
  logic             exp_rvalid;
  logic [MAX_W-1:0] exp_dout;
  logic [MAX_W-1:0] exp_q[$];
  int               due_q[$];
  bit               b2b_pat [9] = '{1, 0, 0, 0, 1, 0, 1, 1, 0};

  task automatic model_reset();
    exp_q.delete();
    due_q.delete();
    m_ready     = 1'b0;
    m_init_left = INIT_CYC;
    m_last      = '0;
    exp_rvalid  = 1'b0;
    exp_dout    = '0;
    m_mem       = '0;
  endtask

  // One rising edge of the specified behaviour, evaluated on the inputs
  // the DUT sees at that edge.
  task automatic model_edge();
    int k, w, a, base;
    logic [MAX_W-1:0] data;
    cyc++;
    exp_rvalid = 1'b0;
    // Oldest read whose latency has elapsed goes out this edge.
    for (int i = 0; i < exp_q.size(); i++) begin
      if (due_q[i] <= cyc) begin
        exp_rvalid = 1'b1;
        m_last = exp_q[i];
        exp_q.delete(i);
        due_q.delete(i);
        break;
      end
    end
    exp_dout = m_last;
    if (m_ready && en && !clear) begin
      k    = (int'(c) > 5) ? 5 : int'(c);
      w    = MAX_W >> k;
      a    = int'(addr) % (TOT / w);
      base = a * w;
      if (wen) begin
        for (int i = 0; i < w; i++) if (wmask[i]) m_mem[base + i] = d_in[i];
      end else begin
        data = '0;
        for (int i = 0; i < w; i++) data[i] = m_mem[base + i];
        exp_q.push_back(data);
        due_q.push_back(cyc + (reg_out ? 2 : 1));
      end
    end
    if (!m_ready) begin
      m_init_left--;
      if (m_init_left == 0) m_ready = 1'b1;
    end else if (clear) begin
      m_ready     = 1'b0;
      m_init_left = INIT_CYC;
      m_mem       = '0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge sram_clk);
    if (sram_rst_n) model_edge();
    #1;
  endtask

  task automatic drive_req(input logic w, input logic [2:0] cc, input logic ro,
                           input logic [ADDR_W-1:0] a, input logic [MAX_W-1:0] d,
                           input logic [MAX_W-1:0] m);
    en = 1'b1; wen = w; c = cc; reg_out = ro; addr = a; d_in = d; wmask = m;
  endtask

  task automatic drive_idle();
    en = 1'b0; wen = 1'b0; clear = 1'b0; d_in = $urandom; wmask = $urandom;
  endtask

  task automatic do_write(input logic [2:0] cc, input logic [ADDR_W-1:0] a,
                          input logic [MAX_W-1:0] d, input logic [MAX_W-1:0] m);
    drive_req(1'b1, cc, 1'b0, a, d, m);
    tick();
    drive_idle();
  endtask

  // Leaves the bench just after the edge that delivers the read.
  task automatic do_read(input logic [2:0] cc, input logic [ADDR_W-1:0] a);
    drive_req(1'b0, cc, 1'b0, a, '0, '0);
    tick();
    drive_idle();
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int k;
    sram_rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge sram_clk);
    #1;
    n_cmp++;
    if (ready !== 1'b0 || rvalid !== 1'b0 || d_out !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b rvalid=%b d_out=%h, required 0 0 00000000", ready, rvalid, d_out);
    end
    sram_rst_n = 1'b1;
    k = 0;
    while (ready !== 1'b1 && k < 2000) begin
      tick();
      k++;
    end
    n_cmp++;
    if (k !== INIT_CYC) begin
      n_fail++;
      $display("FAIL reset_init_len: ready low for %0d cycles, required %0d", k, INIT_CYC);
    end
    n_cmp++;
    if (ready !== m_ready || dbg_state !== m_ready) begin
      n_fail++;
      $display("FAIL reset_idle_state: ready=%b dbg_state=%b, required %b", ready, dbg_state, m_ready);
    end
    drive_req(1'b0, 3'd0, 1'b0, 15'd777, '0, '0);
    tick();
    drive_idle();
    n_cmp++;
    if (rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd777_accept_edge: rvalid=%b, required 0", rvalid);
    end
    tick();
    n_cmp++;
    if (rvalid !== 1'b1 || d_out !== 32'h0 || d_out !== exp_dout) begin
      n_fail++;
      $display("FAIL rd777_data: rvalid=%b d_out=%h, required 1 00000000", rvalid, d_out);
    end
  endtask

  task automatic test_widths();
    do_write(3'd0, 15'd5, 32'hDEADBEEF, 32'hFFFFFFFF);
    do_read(3'd2, 15'd20);
    n_cmp++;
    if (rvalid !== 1'b1 || d_out !== 32'h000000EF || d_out !== exp_dout) begin
      n_fail++;
      $display("FAIL c2_addr20: rvalid=%b d_out=%h, required 1 000000EF", rvalid, d_out);
    end
    do_read(3'd2, 15'd23);
    n_cmp++;
    if (rvalid !== 1'b1 || d_out !== 32'h000000DE) begin
      n_fail++;
      $display("FAIL c2_addr23: rvalid=%b d_out=%h, required 1 000000DE", rvalid, d_out);
    end
    tick();
    n_cmp++;
    if (rvalid !== 1'b0 || d_out !== 32'h000000DE) begin
      n_fail++;
      $display("FAIL dout_hold: rvalid=%b d_out=%h, required 0 000000DE", rvalid, d_out);
    end
    // masked write followed directly by a read of the same word
    drive_req(1'b1, 3'd0, 1'b0, 15'd5, 32'h12345678, 32'h0000FF00);
    tick();
    n_cmp++;
    if (rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL write_no_rvalid: rvalid=%b, required 0", rvalid);
    end
    drive_req(1'b0, 3'd0, 1'b0, 15'd5, '0, '0);
    tick();
    drive_idle();
    tick();
    n_cmp++;
    if (rvalid !== 1'b1 || d_out !== 32'hDEAD56EF || d_out !== exp_dout) begin
      n_fail++;
      $display("FAIL masked_write: rvalid=%b d_out=%h, required 1 DEAD56EF", rvalid, d_out);
    end
    do_read(3'd0, 15'h7C05);
    n_cmp++;
    if (rvalid !== 1'b1 || d_out !== 32'hDEAD56EF) begin
      n_fail++;
      $display("FAIL upper_addr_ignored: rvalid=%b d_out=%h, required 1 DEAD56EF", rvalid, d_out);
    end
    do_write(3'd5, 15'd32767, 32'h00000001, 32'hFFFFFFFF);
    do_read(3'd0, 15'd1023);
    n_cmp++;
    if (rvalid !== 1'b1 || d_out !== 32'h80000000) begin
      n_fail++;
      $display("FAIL c5_bit_write: rvalid=%b d_out=%h, required 1 80000000", rvalid, d_out);
    end
    do_write(3'd6, 15'd32700, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_read(3'd0, 15'd1021);
    n_cmp++;
    if (rvalid !== 1'b1 || d_out !== 32'h10000000 || d_out !== exp_dout) begin
      n_fail++;
      $display("FAIL c6_bit_write: rvalid=%b d_out=%h, required 1 10000000", rvalid, d_out);
    end
    do_read(3'd6, 15'd32700);
    n_cmp++;
    if (rvalid !== 1'b1 || d_out !== 32'h00000001) begin
      n_fail++;
      $display("FAIL c6_zero_extend: rvalid=%b d_out=%h, required 1 00000001", rvalid, d_out);
    end
  endtask

  task automatic test_back_to_back();
    int n_rv;
    drive_req(1'b0, 3'd0, 1'b1, 15'd5, '0, '0);
    tick();
    n_cmp++;
    if (rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_t0: rvalid=%b, required 0", rvalid);
    end
    drive_req(1'b0, 3'd0, 1'b0, 15'd1023, '0, '0);
    tick();
    drive_idle();
    n_cmp++;
    if (rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_t1: rvalid=%b, required 0", rvalid);
    end
    tick();
    n_cmp++;
    if (rvalid !== 1'b1 || d_out !== 32'hDEAD56EF) begin
      n_fail++;
      $display("FAIL b2b_older_first: rvalid=%b d_out=%h, required 1 DEAD56EF", rvalid, d_out);
    end
    tick();
    n_cmp++;
    if (rvalid !== 1'b1 || d_out !== 32'h80000000) begin
      n_fail++;
      $display("FAIL b2b_newer_next: rvalid=%b d_out=%h, required 1 80000000", rvalid, d_out);
    end
    tick();
    n_cmp++;
    if (rvalid !== 1'b0 || d_out !== 32'h80000000) begin
      n_fail++;
      $display("FAIL b2b_idle_hold: rvalid=%b d_out=%h, required 0 80000000", rvalid, d_out);
    end
    // longer mixed-latency burst, checked every cycle
    n_rv = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 9) drive_req(1'b0, 3'($urandom_range(0, 7)), b2b_pat[i], ADDR_W'($urandom_range(0, 1023)), '0, '0);
      else drive_idle();
      tick();
      if (rvalid === 1'b1) n_rv++;
      n_cmp++;
      if (rvalid !== exp_rvalid || d_out !== exp_dout) begin
        n_fail++;
        $display("FAIL b2b_burst cyc=%0d: rvalid=%b d_out=%h, required %b %h", i, rvalid, d_out, exp_rvalid, exp_dout);
      end
    end
    n_cmp++;
    if (n_rv !== 9) begin
      n_fail++;
      $display("FAIL b2b_burst_count: %0d rvalid strobes, required 9", n_rv);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en      = ($urandom_range(0, 3) != 0);
      wen     = 1'($urandom_range(0, 1));
      c       = 3'($urandom_range(0, 7));
      reg_out = 1'($urandom_range(0, 1));
      addr    = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 63)) : ADDR_W'($urandom);
      d_in    = $urandom;
      wmask   = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : $urandom;
      tick();
      n_cmp++;
      if (rvalid !== exp_rvalid || d_out !== exp_dout) begin
        n_fail++;
        $display("FAIL rnd_read cyc=%0d: rvalid=%b d_out=%h, required %b %h", i, rvalid, d_out, exp_rvalid, exp_dout);
      end
      n_cmp++;
      if (ready !== m_ready) begin
        n_fail++;
        $display("FAIL rnd_ready cyc=%0d: ready=%b, required %b", i, ready, m_ready);
      end
    end
    drive_idle();
    repeat (3) tick();
  endtask

  task automatic test_clear();
    int k, n_rv;
    do_write(3'd0, 15'd5, 32'hDEAD56EF, 32'hFFFFFFFF);
    drive_req(1'b0, 3'd0, 1'b1, 15'd5, '0, '0);
    tick();
    drive_req(1'b1, 3'd0, 1'b0, 15'd5, 32'h11111111, 32'hFFFFFFFF);
    clear = 1'b1;
    tick();
    drive_idle();
    n_cmp++;
    if (ready !== 1'b0 || rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_edge: ready=%b rvalid=%b, required 0 0", ready, rvalid);
    end
    k = 0;
    tick();
    k++;
    n_cmp++;
    if (rvalid !== 1'b1 || d_out !== 32'hDEAD56EF || d_out !== exp_dout) begin
      n_fail++;
      $display("FAIL clr_inflight_read: rvalid=%b d_out=%h, required 1 DEAD56EF", rvalid, d_out);
    end
    n_rv = 0;
    while (ready !== 1'b1 && k < 2000) begin
      if (k == 300) begin
        drive_req(1'b0, 3'd0, 1'b0, 15'd5, '0, '0);
        clear = 1'b1;
      end
      tick();
      k++;
      drive_idle();
      if (rvalid === 1'b1) n_rv++;
    end
    n_cmp++;
    if (k !== INIT_CYC) begin
      n_fail++;
      $display("FAIL clr_init_len: ready low for %0d cycles, required %0d", k, INIT_CYC);
    end
    n_cmp++;
    if (n_rv !== 0) begin
      n_fail++;
      $display("FAIL clr_no_rvalid: %0d strobes during fill, required 0", n_rv);
    end
    do_read(3'd0, 15'd5);
    n_cmp++;
    if (rvalid !== 1'b1 || d_out !== 32'h0) begin
      n_fail++;
      $display("FAIL clr_zeroed: rvalid=%b d_out=%h, required 1 00000000", rvalid, d_out);
    end
    // reset in the middle of the fill restarts it from word 0
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (500) tick();
    sram_rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (ready !== 1'b0 || rvalid !== 1'b0 || d_out !== '0) begin
      n_fail++;
      $display("FAIL clr_rst_async: ready=%b rvalid=%b d_out=%h, required 0 0 00000000", ready, rvalid, d_out);
    end
    repeat (2) @(posedge sram_clk);
    #1;
    sram_rst_n = 1'b1;
    k = 0;
    while (ready !== 1'b1 && k < 2000) begin
      tick();
      k++;
    end
    n_cmp++;
    if (k !== INIT_CYC) begin
      n_fail++;
      $display("FAIL clr_rst_restart: ready low for %0d cycles, required %0d", k, INIT_CYC);
    end
  endtask

  task automatic test_reset_abort();
    int k, n_rv;
    do_write(3'd0, 15'd9, 32'hA5A55A5A, 32'hFFFFFFFF);
    do_read(3'd0, 15'd9);
    n_cmp++;
    if (rvalid !== 1'b1 || d_out !== 32'hA5A55A5A) begin
      n_fail++;
      $display("FAIL abort_setup: rvalid=%b d_out=%h, required 1 A5A55A5A", rvalid, d_out);
    end
    drive_req(1'b0, 3'd0, 1'b1, 15'd9, '0, '0);
    tick();
    drive_idle();
    sram_rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (ready !== 1'b0 || rvalid !== 1'b0 || d_out !== '0) begin
      n_fail++;
      $display("FAIL abort_async: ready=%b rvalid=%b d_out=%h, required 0 0 00000000", ready, rvalid, d_out);
    end
    repeat (2) @(posedge sram_clk);
    #1;
    sram_rst_n = 1'b1;
    k = 0;
    n_rv = 0;
    while (ready !== 1'b1 && k < 2000) begin
      tick();
      k++;
      if (rvalid === 1'b1) n_rv++;
    end
    n_cmp++;
    if (n_rv !== 0 || k !== INIT_CYC) begin
      n_fail++;
      $display("FAIL abort_no_result: strobes=%0d fill=%0d, required 0 %0d", n_rv, k, INIT_CYC);
    end
    do_read(3'd0, 15'd9);
    n_cmp++;
    if (rvalid !== 1'b1 || d_out !== 32'h0 || d_out !== exp_dout) begin
      n_fail++;
      $display("FAIL abort_zeroed: rvalid=%b d_out=%h, required 1 00000000", rvalid, d_out);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_widths();
    test_back_to_back();
    test_random();
    test_clear();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/config_sram.md
CONFIG_SRAM -- requirements
Module: config_sram

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 15, meaning log2 of total storage bits.
REQ-002 The block SHALL have parameter MAX_W, default 32, meaning the widest word in bits; it is a power of 2.
REQ-003 The block SHALL have localparam LG_MAX = log2(MAX_W) and localparam NWORDS = 2^ADDR_W / MAX_W.
REQ-004 The block SHALL have port sram_clk, input, 1 bit, the single clock; all logic is posedge-triggered.
REQ-005 The block SHALL have port sram_rst_n, input, 1 bit, reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port en, input, 1 bit, request valid.
REQ-007 The block SHALL have port wen, input, 1 bit, request type (1 = write, 0 = read).
REQ-008 The block SHALL have port addr, input, ADDR_W bits, the word address at the current width.
REQ-009 The block SHALL have port d_in, input, MAX_W bits, write data (LSB-aligned).
REQ-010 The block SHALL have port wmask, input, MAX_W bits, per-bit write enable (LSB-aligned).
REQ-011 The block SHALL have port c, input, 3 bits, width config: word width W = MAX_W >> c; c > LG_MAX is treated as W = 1.
REQ-012 The block SHALL have port reg_out, input, 1 bit, which adds one output register stage to this request.
REQ-013 The block SHALL have port clear, input, 1 bit, which requests a zero-fill of the whole array.
REQ-014 The block SHALL have port ready, output, 1 bit, meaning requests are accepted.
REQ-015 The block SHALL have port d_out, output, MAX_W bits, read data.
REQ-016 The block SHALL have port rvalid, output, 1 bit, a 1-cycle strobe marking d_out valid.

Function
REQ-017 A request SHALL be accepted on a posedge where en=1, ready=1 and clear=0; en is ignored otherwise.
REQ-018 For accepted requests, c, reg_out, addr, d_in and wmask SHALL be sampled at the accept edge and applied to that request only.
REQ-019 Only the low (ADDR_W - LG_MAX + min(c, LG_MAX)) address bits SHALL be used; upper bits are ignored.
REQ-020 The word SHALL occupy storage bits [A*W +: W], where A is the used address.
REQ-021 A write SHALL update storage bit A*W+i to d_in[i] only where wmask[i]=1, for i < W; d_in/wmask bits at i >= W are ignored.
REQ-022 Write data SHALL be visible to a read accepted on the next cycle.
REQ-023 A read SHALL return the word zero-extended to MAX_W, i.e. d_out bits at i >= W are 0.
REQ-024 Read latency with reg_out=0 SHALL be 1 cycle: d_out and rvalid update at accept+1 edge.
REQ-025 Read latency with reg_out=1 SHALL be 2 cycles: d_out and rvalid update at accept+2 edge.
REQ-026 When reg_out=0 and reg_out=1 reads are interleaved back-to-back and would collide on the same output edge, the reg_out=1 (older) result SHALL win, and the newer result SHALL be delivered one cycle later with no data loss.
REQ-027 d_out SHALL hold its last value between reads.
REQ-028 rvalid SHALL be 0 on writes and on idle cycles.
REQ-029 The FSM SHALL have two states, INIT and IDLE, plus a counter cnt of width log2(NWORDS)+1.
REQ-030 In INIT, ready SHALL be 0, and each cycle MAX_W bits at word cnt SHALL be zeroed and cnt incremented.
REQ-031 The FSM SHALL go INIT->IDLE on the edge that clears word NWORDS-1; ready becomes 1 on that edge.
REQ-032 In IDLE, ready SHALL be 1, and clear=1 SHALL cause IDLE->INIT with cnt=0 on the next edge; clear has priority over en in the same cycle.
REQ-033 Reads accepted before INIT entry SHALL still complete their output pipeline during INIT, returning pre-clear data.
REQ-034 clear asserted while in INIT SHALL be ignored and SHALL NOT restart the count.

Reset
REQ-035 When sram_rst_n=0, the block SHALL asynchronously set d_out=0, rvalid=0, ready=0, FSM=INIT, cnt=0, and flush all pipeline stages.
REQ-036 On release of sram_rst_n, zero-fill SHALL start on the first posedge, so contents are all-zero before ready rises.
REQ-037 Reset asserted mid-INIT or mid-read SHALL abort all activity; no rvalid is issued for requests in flight.

Verification (ADDR_W=15, MAX_W=32)
REQ-038 Release reset -> ready=0 for exactly 1024 cycles, then 1; a c=0 read of addr 777 returns 0x00000000 with rvalid at +1.
REQ-039 c=0 write addr 5 0xDEADBEEF mask 0xFFFFFFFF -> c=2 read addr 20 returns 0x000000EF, addr 23 returns 0x000000DE.
REQ-040 Then c=0 write addr 5 0x12345678 mask 0x0000FF00 -> c=0 read addr 5 returns 0xDEAD56EF.
REQ-041 c=5 write addr 32767 data 1 -> c=0 read addr 1023 returns 0x80000000; c=6 behaves identically to c=5.
REQ-042 Back-to-back reads: reg_out=1 addr 5 at T, reg_out=0 addr 1023 at T+1 -> rvalid at T+2 (0xDEAD56EF) and T+3 (0x80000000).
REQ-043 clear and en high in the same cycle -> request dropped, ready=0 for 1024 cycles, addr 5 then reads 0; reset asserted at cnt=500 -> count restarts from 0.
